// File: rtl/mem_arbiter_ctrl.sv
// mem_arbiter_ctrl: N-port arbiter in front of a single-port
// byte-writable word store with registered per-port responses.
module mem_arbiter_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16,
  parameter int DEPTH      = 1024,
  parameter int NUM_PORTS  = 3,
  parameter int ARB_MODE   = 1
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_PORTS-1:0]              req_en,
  input  logic [NUM_PORTS-1:0]              req_wr,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0]   req_addr,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]   req_wdata,
  input  logic [NUM_PORTS*DATA_WIDTH/8-1:0] req_be,
  output logic [NUM_PORTS-1:0]              req_gnt,
  output logic [NUM_PORTS-1:0]              rsp_valid,
  output logic [NUM_PORTS*DATA_WIDTH-1:0]   rsp_rdata,
  output logic [NUM_PORTS-1:0]              rsp_err
);

  localparam int BW  = DATA_WIDTH / 8;
  localparam int PW  = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int MW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int AW1 = ADDR_WIDTH + 1;

  localparam logic [PW-1:0]  LAST_RST = PW'(NUM_PORTS - 1);
  localparam logic [AW1-1:0] DEPTH_L  = AW1'(DEPTH);

  // Storage, deliberately without reset so contents survive rst.
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  logic [PW-1:0]         r_last_gnt;
  logic [NUM_PORTS-1:0]  r_valid;
  logic [NUM_PORTS-1:0]  r_err;
  logic [DATA_WIDTH-1:0] r_rdata [NUM_PORTS];

  logic [PW-1:0]         w_sel;
  logic                  w_any;
  logic [NUM_PORTS-1:0]  w_gnt;
  logic                  w_wr;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [DATA_WIDTH-1:0] w_wdata;
  logic [BW-1:0]         w_be;
  logic                  w_in_range;
  logic [MW-1:0]         w_mem_idx;

  // Arbitration: pick one requester, fixed or round-robin.
  // The round-robin scan walks offsets from far to near so the
  // nearest port after last_gnt is written last and wins.
  always_comb begin
    int idx;
    w_sel = '0;
    w_any = 1'b0;
    idx   = 0;
    if (ARB_MODE == 0) begin
      for (int i = NUM_PORTS - 1; i >= 0; i--) begin
        if (req_en[i]) begin
          w_sel = PW'(i);
          w_any = 1'b1;
        end
      end
    end else begin
      for (int i = NUM_PORTS; i >= 1; i--) begin
        idx = (int'(r_last_gnt) + i) % NUM_PORTS;
        if (req_en[idx]) begin
          w_sel = PW'(idx);
          w_any = 1'b1;
        end
      end
    end
    if (rst) begin
      w_any = 1'b0;
    end
  end

  // One-hot grant built from the winning index.
  always_comb begin
    w_gnt        = '0;
    w_gnt[w_sel] = w_any;
  end

  assign req_gnt = w_gnt;

  // Steer the winning port's request fields onto the array.
  always_comb begin
    w_wr       = req_wr[w_sel];
    w_addr     = req_addr[w_sel*ADDR_WIDTH +: ADDR_WIDTH];
    w_wdata    = req_wdata[w_sel*DATA_WIDTH +: DATA_WIDTH];
    w_be       = req_be[w_sel*BW +: BW];
    w_in_range = ({1'b0, w_addr} < DEPTH_L);
    w_mem_idx  = w_addr[MW-1:0];
  end

  // Byte-masked write of the accepted in-range request.
  always_ff @(posedge clk) begin
    if (w_any && w_wr && w_in_range) begin
      for (int b = 0; b < BW; b++) begin
        if (w_be[b]) begin
          r_mem[w_mem_idx][b*8 +: 8] <= w_wdata[b*8 +: 8];
        end
      end
    end
  end

  // Response pipeline and round-robin pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid    <= '0;
      r_err      <= '0;
      r_last_gnt <= LAST_RST;
      for (int p = 0; p < NUM_PORTS; p++) begin
        r_rdata[p] <= '0;
      end
    end else begin
      r_valid <= w_gnt;
      r_err   <= '0;
      if (w_any) begin
        r_last_gnt   <= w_sel;
        r_err[w_sel] <= !w_in_range;
        if (!w_wr) begin
          r_rdata[w_sel] <= w_in_range ? r_mem[w_mem_idx] : '0;
        end
      end
    end
  end

  // Flatten per-port read data onto the output bus.
  always_comb begin
    rsp_rdata = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      rsp_rdata[p*DATA_WIDTH +: DATA_WIDTH] = r_rdata[p];
    end
  end

  assign rsp_valid = r_valid;
  assign rsp_err   = r_err;

endmodule

// File: tb/tb_mem_arbiter_ctrl.sv
// tb_mem_arbiter_ctrl: directed checks of arbitration, byte
// writes, range errors and reset on two arbiter configurations.
module tb_mem_arbiter_ctrl;

  logic        clk;
  logic        rst;

  logic [2:0]  en, wr;
  logic [47:0] addr;
  logic [95:0] wdata;
  logic [11:0] be;
  logic [2:0]  gnt, vld, err;
  logic [95:0] rdata;

  logic [2:0]  fen, fwr;
  logic [47:0] faddr;
  logic [95:0] fwdata;
  logic [11:0] fbe;
  logic [2:0]  fgnt, fvld, ferr;
  logic [95:0] frdata;

  int n_cmp = 0;
  int n_err = 0;

  mem_arbiter_ctrl #(
    .DATA_WIDTH(32), .ADDR_WIDTH(16), .DEPTH(1024),
    .NUM_PORTS(3), .ARB_MODE(1)
  ) u_rr (
    .clk(clk), .rst(rst),
    .req_en(en), .req_wr(wr), .req_addr(addr),
    .req_wdata(wdata), .req_be(be),
    .req_gnt(gnt), .rsp_valid(vld),
    .rsp_rdata(rdata), .rsp_err(err)
  );

  mem_arbiter_ctrl #(
    .DATA_WIDTH(32), .ADDR_WIDTH(16), .DEPTH(1024),
    .NUM_PORTS(3), .ARB_MODE(0)
  ) u_fp (
    .clk(clk), .rst(rst),
    .req_en(fen), .req_wr(fwr), .req_addr(faddr),
    .req_wdata(fwdata), .req_be(fbe),
    .req_gnt(fgnt), .rsp_valid(fvld),
    .rsp_rdata(frdata), .rsp_err(ferr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input int p, input logic e, input logic w,
                     input logic [15:0] a, input logic [31:0] d,
                     input logic [3:0] b);
    en[p]          = e;
    wr[p]          = w;
    addr[p*16+:16] = a;
    wdata[p*32+:32] = d;
    be[p*4+:4]     = b;
  endtask

  function automatic logic [31:0] rd(input int p);
    return rdata[p*32+:32];
  endfunction

  logic [2:0] rr_seq [6];

  initial begin
    rr_seq = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
    en = '0; wr = '0; addr = '0; wdata = '0; be = '0;
    fen = '0; fwr = '0; faddr = '0; fwdata = '0; fbe = '0;

    // reset with requests pending: no grants
    rst = 1'b1;
    en  = 3'b111;
    #1;
    chk("rst_gnt", 64'(gnt), 64'h0);
    step();
    step();
    chk("rst_vld", 64'(vld), 64'h0);
    chk("rst_err", 64'(err), 64'h0);
    chk("rst_rdata", 64'(rdata[63:0]), 64'h0);
    rst = 1'b0;
    en  = '0;

    // single port write then read of addr 5
    drv(0, 1, 1, 16'd5, 32'hDEADBEEF, 4'hF);
    #1 chk("wr5_gnt", 64'(gnt), 64'h1);
    step();
    chk("wr5_vld", 64'(vld), 64'h1);
    chk("wr5_err", 64'(err), 64'h0);
    drv(0, 1, 0, 16'd5, 32'h0, 4'h0);
    #1 chk("rd5_gnt", 64'(gnt), 64'h1);
    step();
    chk("rd5_vld", 64'(vld), 64'h1);
    chk("rd5_data", 64'(rd(0)), 64'hDEADBEEF);
    chk("rd5_err", 64'(err), 64'h0);

    // byte enables on addr 7
    drv(0, 1, 1, 16'd7, 32'h11223344, 4'hF);
    step();
    chk("wr7_hold", 64'(rd(0)), 64'hDEADBEEF);
    drv(0, 1, 1, 16'd7, 32'hAABBCCDD, 4'h5);
    step();
    chk("wr7b_vld", 64'(vld), 64'h1);
    drv(0, 1, 0, 16'd7, 32'h0, 4'h0);
    step();
    chk("rd7_data", 64'(rd(0)), 64'h11BB33DD);
    drv(0, 0, 0, 16'd0, 32'h0, 4'h0);
    step();
    chk("idle_vld", 64'(vld), 64'h0);
    chk("rd7_hold", 64'(rd(0)), 64'h11BB33DD);

    // P1 writes addr 0, P2 reads addr 5
    drv(1, 1, 1, 16'd0, 32'hCAFEF00D, 4'hF);
    #1 chk("wr0_gnt", 64'(gnt), 64'h2);
    step();
    drv(1, 0, 0, 16'd0, 32'h0, 4'h0);
    drv(2, 1, 0, 16'd5, 32'h0, 4'h0);
    #1 chk("p2rd_gnt", 64'(gnt), 64'h4);
    step();
    chk("p2rd_data", 64'(rd(2)), 64'hDEADBEEF);

    // out-of-range write and read on P2
    drv(2, 1, 1, 16'd1024, 32'h12345678, 4'hF);
    step();
    chk("oor_wr_vld", 64'(vld), 64'h4);
    chk("oor_wr_err", 64'(err), 64'h4);
    drv(2, 1, 0, 16'd1024, 32'h0, 4'h0);
    step();
    chk("oor_rd_vld", 64'(vld), 64'h4);
    chk("oor_rd_err", 64'(err), 64'h4);
    chk("oor_rd_data", 64'(rd(2)), 64'h0);
    drv(2, 1, 0, 16'd0, 32'h0, 4'h0);
    step();
    chk("rd0_data", 64'(rd(2)), 64'hCAFEF00D);
    chk("rd0_err", 64'(err), 64'h0);
    drv(2, 0, 0, 16'd0, 32'h0, 4'h0);

    // reset, then three contending readers rotate from P0
    rst = 1'b1;
    step();
    rst = 1'b0;
    drv(0, 1, 0, 16'd5, 32'h0, 4'h0);
    drv(1, 1, 0, 16'd7, 32'h0, 4'h0);
    drv(2, 1, 0, 16'd0, 32'h0, 4'h0);
    for (int c = 0; c < 6; c++) begin
      #1 chk($sformatf("rr_gnt%0d", c), 64'(gnt), 64'(rr_seq[c]));
      step();
      chk($sformatf("rr_vld%0d", c), 64'(vld), 64'(rr_seq[c]));
    end
    chk("rr_p0_data", 64'(rd(0)), 64'hDEADBEEF);
    chk("rr_p1_data", 64'(rd(1)), 64'h11BB33DD);
    chk("rr_p2_data", 64'(rd(2)), 64'hCAFEF00D);
    en = '0;
    step();

    // reset right after a read acceptance kills the response
    drv(0, 1, 0, 16'd5, 32'h0, 4'h0);
    #1 chk("mr_gnt", 64'(gnt), 64'h1);
    step();
    rst = 1'b1;
    en  = '0;
    #1 chk("mr_rst_gnt", 64'(gnt), 64'h0);
    step();
    chk("mr_vld", 64'(vld), 64'h0);
    chk("mr_rdata", 64'(rd(0)), 64'h0);
    rst = 1'b0;
    drv(0, 1, 0, 16'd5, 32'h0, 4'h0);
    step();
    chk("mr_after_vld", 64'(vld), 64'h1);
    chk("mr_after_data", 64'(rd(0)), 64'hDEADBEEF);
    en = '0;

    // fixed priority: P1 starves P2 until it drops
    fen = 3'b110;
    faddr[16+:16] = 16'd1;
    faddr[32+:16] = 16'd2000;
    for (int c = 0; c < 4; c++) begin
      #1 chk($sformatf("fp_gnt%0d", c), 64'(fgnt), 64'h2);
      step();
      chk($sformatf("fp_vld%0d", c), 64'(fvld), 64'h2);
    end
    fen = 3'b111;
    #1 chk("fp_p0_gnt", 64'(fgnt), 64'h1);
    step();
    fen = 3'b100;
    #1 chk("fp_p2_gnt", 64'(fgnt), 64'h4);
    step();
    chk("fp_p2_vld", 64'(fvld), 64'h4);
    chk("fp_p2_err", 64'(ferr), 64'h4);
    chk("fp_p2_data", 64'(frdata[64+:32]), 64'h0);
    fen = '0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
